multiplier_sequential: RTL and testbench

MULTIPLIER_SEQUENTIAL -- requirements
Module: multiplier_sequential

---
 rtl/multiplier_sequential.sv | 102 ++++++++++
 tb/tb_multiplier_sequential.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_sequential.sv
// Radix-2 shift-and-add unsigned multiplier: one multiplier bit per clock, fixed WIDTH-cycle run,
// registered result/Busy/Done outputs.
module multiplier_sequential #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               Busy,
  output logic               Done
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] acc_sum;

  // Accumulator is 2*WIDTH wide, so the sum of all shifted partial products cannot overflow.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          mcand_d  = {{WIDTH{1'b0}}, multiplicand};
          mplier_d = multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d = acc_sum;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_multiplier_sequential.sv
// Bench for multiplier_sequential: WIDTH=2/4/8 instances checked every cycle against an
// operation-level reference model (product via plain multiplication, fixed-latency countdown).
module tb_multiplier_sequential;

  int unsigned wid[3] = '{2, 4, 8};

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] start;
  logic [7:0] op_a[3];
  logic [7:0] op_b[3];
  logic [3:0]  res2;
  logic [7:0]  res4;
  logic [15:0] res8;
  logic [2:0]  busy;
  logic [2:0]  done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one slot per instance.
  int     m_phase[3];  // 0 idle, 1 running, 2 done cycle
  int     m_left[3];
  longint m_prod[3];
  longint m_res[3];
  bit     m_busy[3];
  bit     m_done[3];
  int     done_seen[3];

  always #5 clk = ~clk;

  multiplier_sequential #(.WIDTH(2)) u_w2 (
    .Clk(clk), .Reset(rst[0]), .Start(start[0]),
    .multiplicand(op_a[0][1:0]), .multiplier(op_b[0][1:0]),
    .result(res2), .Busy(busy[0]), .Done(done[0])
  );

  multiplier_sequential #(.WIDTH(4)) u_w4 (
    .Clk(clk), .Reset(rst[1]), .Start(start[1]),
    .multiplicand(op_a[1][3:0]), .multiplier(op_b[1][3:0]),
    .result(res4), .Busy(busy[1]), .Done(done[1])
  );

  multiplier_sequential #(.WIDTH(8)) u_w8 (
    .Clk(clk), .Reset(rst[2]), .Start(start[2]),
    .multiplicand(op_a[2]), .multiplier(op_b[2]),
    .result(res8), .Busy(busy[2]), .Done(done[2])
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] obs_res(input int i);
    case (i)
      0:       return 64'(res2);
      1:       return 64'(res4);
      default: return 64'(res8);
    endcase
  endfunction

  function automatic longint mask_op(input int i, input logic [7:0] v);
    return longint'(v) & ((longint'(1) << wid[i]) - 1);
  endfunction

  task automatic model_step(input int i);
    if (rst[i]) begin
      m_phase[i] = 0;
      m_res[i]   = 0;
      m_busy[i]  = 1'b0;
      m_done[i]  = 1'b0;
    end else begin
      m_done[i] = 1'b0;
      case (m_phase[i])
        0: if (start[i]) begin
          m_prod[i]  = mask_op(i, op_a[i]) * mask_op(i, op_b[i]);
          m_left[i]  = int'(wid[i]);
          m_busy[i]  = 1'b1;
          m_phase[i] = 1;
        end
        1: begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_res[i]   = m_prod[i];
            m_busy[i]  = 1'b0;
            m_done[i]  = 1'b1;
            m_phase[i] = 2;
          end
        end
        default: m_phase[i] = 0;
      endcase
    end
  endtask

  // Advance one clock, update the model with the inputs the DUTs saw, then compare all outputs.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("w%0d_busy", wid[i]), 64'(busy[i]), 64'(m_busy[i]));
      check_val($sformatf("w%0d_done", wid[i]), 64'(done[i]), 64'(m_done[i]));
      check_val($sformatf("w%0d_result", wid[i]), obs_res(i), 64'(m_res[i]));
      if (done[i] === 1'b1) done_seen[i]++;
    end
  endtask

  // One operation; operands are scrambled while running to show they are not re-sampled.
  task automatic run_op(input int i, input int a, input int b);
    start[i] = 1'b1;
    op_a[i]  = 8'(a);
    op_b[i]  = 8'(b);
    tick();
    start[i] = 1'b0;
    repeat (wid[i] + 1) begin
      op_a[i] = 8'($urandom);
      op_b[i] = 8'($urandom);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_left[i] = 0; m_prod[i] = 0; m_res[i] = 0;
      m_busy[i] = 1'b0; m_done[i] = 1'b0; done_seen[i] = 0;
      op_a[i] = '0; op_b[i] = '0;
    end
    rst   = 3'b111;
    start = 3'b111;  // Start coincident with Reset must be ignored
    tick();
    start = 3'b000;
    tick();
    rst = 3'b000;
    for (int i = 0; i < 3; i++) check_val($sformatf("w%0d_reset_res", wid[i]), obs_res(i), 64'd0);
    tick();

    // WIDTH=2: exhaustive operand pairs.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        run_op(0, a, b);
        check_val($sformatf("w2_%0dx%0d", a, b), 64'(res2), 64'(a * b));
      end

    // WIDTH=4 directed cases.
    run_op(1, 15, 15);
    check_val("w4_15x15", 64'(res4), 64'd225);
    done_seen[1] = 0;
    run_op(1, 0, 13);
    check_val("w4_0x13", 64'(res4), 64'd0);
    check_val("w4_0x13_dones", 64'(done_seen[1]), 64'd1);

    // Start 7x9, then a 1x1 Start pulse mid-run that must be ignored.
    done_seen[1] = 0;
    start[1] = 1'b1; op_a[1] = 8'd7; op_b[1] = 8'd9;
    tick();
    start[1] = 1'b0;
    tick();
    start[1] = 1'b1; op_a[1] = 8'd1; op_b[1] = 8'd1;
    tick();
    start[1] = 1'b0;
    repeat (6) tick();
    check_val("w4_7x9", 64'(res4), 64'd63);
    check_val("w4_7x9_dones", 64'(done_seen[1]), 64'd1);

    // Reset during run of 12x11 aborts with no Done.
    done_seen[1] = 0;
    start[1] = 1'b1; op_a[1] = 8'd12; op_b[1] = 8'd11;
    tick();
    start[1] = 1'b0;
    repeat (3) tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check_val("w4_abort_res", 64'(res4), 64'd0);
    check_val("w4_abort_busy", 64'(busy[1]), 64'd0);
    repeat (6) tick();
    check_val("w4_abort_dones", 64'(done_seen[1]), 64'd0);

    // Start held high: back-to-back 5x6 every WIDTH+2 cycles.
    done_seen[1] = 0;
    start[1] = 1'b1; op_a[1] = 8'd5; op_b[1] = 8'd6;
    repeat (20) tick();
    start[1] = 1'b0;
    check_val("w4_held_dones", 64'(done_seen[1]), 64'd3);
    check_val("w4_held_res", 64'(res4), 64'd30);
    repeat (6) tick();

    // WIDTH=8 full-scale operands.
    run_op(2, 255, 255);
    check_val("w8_255x255", 64'(res8), 64'd65025);

    // Random traffic on all instances, with occasional resets.
    repeat (400) begin
      for (int i = 0; i < 3; i++) begin
        start[i] = ($urandom_range(0, 2) == 0);
        op_a[i]  = 8'($urandom);
        op_b[i]  = 8'($urandom);
        rst[i]   = ($urandom_range(0, 39) == 0);
      end
      tick();
    end
    start = 3'b000;
    rst   = 3'b000;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
